// File: rtl/tty_pkg.sv
// tty_pkg: shared types and constants for the terminal receive queue.
//   rd_state_t   - read FSM state encoding (IDLE, POP, HOLD)
//   CHAR_W       - character width in bits
//   RD_VALID_BIT - position of the valid flag inside the 32-bit read word
package tty_pkg;

  localparam int CHAR_W       = 8;
  localparam int RD_VALID_BIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    HOLD = 2'd2
  } rd_state_t;

endpackage

// File: rtl/tty_sync_fifo.sv
// tty_sync_fifo: DEPTH x CHAR_W synchronous FIFO with registered status.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   push        - write request; accepted when not full, or when a pop
//                 happens on the same edge
//   push_data   - byte to write
//   push_accept - combinational: push is taken on this edge
//   pop         - read request; ignored when empty
//   head        - oldest entry (combinational read of the head slot)
//   count       - registered occupancy, 0..DEPTH
//   full, empty - registered flags derived from the next count
module tty_sync_fifo
  import tty_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [CHAR_W-1:0] push_data,
  output logic              push_accept,
  input  logic              pop,
  output logic [CHAR_W-1:0] head,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_pop;
  logic [AW:0]       count_next;

  assign do_pop      = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_accept = push & (~full | do_pop);
  assign head        = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push_accept, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: storage has no reset; only pointers and count define what is valid,
  // so resetting the array would just cost logic.
  always_ff @(posedge clk) begin
    if (push_accept) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      // Pointers are AW bits wide, so increment wraps modulo DEPTH.
      if (push_accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)      rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/tty_rx_queue.sv
// tty_rx_queue: merges keyboard and UART bytes into one FIFO read by the CPU.
// Ports:
//   clk_50mhz, rst       - clock, asynchronous active-high reset
//   kb_valid/kb_data     - keyboard character pulse and byte
//   rx_valid/rx_data     - UART byte pulse and byte
//   rd                   - CPU read strobe (level); one pop per assertion
//   rd_data              - {23'b0, valid, char}, updated after the POP cycle
//   not_empty/full/count - registered FIFO status
//   overflow / clr_ovf   - sticky drop flag and its synchronous clear
// Optional build macro TTY_RXQ_ECHO_EN adds echo_valid/echo_data: a one-cycle
// pulse with the byte for every character accepted into the FIFO.
module tty_rx_queue
  import tty_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic              kb_valid,
  input  logic [CHAR_W-1:0] kb_data,
  input  logic              rx_valid,
  input  logic [CHAR_W-1:0] rx_data,
  input  logic              rd,
  output logic [31:0]       rd_data,
  output logic              not_empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              overflow,
  input  logic              clr_ovf
`ifdef TTY_RXQ_ECHO_EN
  ,
  output logic              echo_valid,
  output logic [CHAR_W-1:0] echo_data
`endif
);

  // ---------------------------------------------------------------------------
  // Push arbitration and pending slot
  // ---------------------------------------------------------------------------
  logic              pend_valid, pend_valid_next;
  logic [CHAR_W-1:0] pend_data, pend_data_next;
  logic              push_req;
  logic [CHAR_W-1:0] push_byte;
  logic              arb_drop;
  logic              push_accept;
  logic              pop_req;
  logic              empty;
  logic [CHAR_W-1:0] head;

  // A waiting pending byte always goes first. Whatever arrives behind it
  // refills the slot (kb before rx); a second arrival in that cycle is lost.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    push_req        = 1'b0;
    push_byte       = '0;
    pend_valid_next = 1'b0;
    pend_data_next  = pend_data;
    arb_drop        = 1'b0;
    if (pend_valid) begin
      push_req  = 1'b1;
      push_byte = pend_data;
      if (kb_valid) begin
        pend_valid_next = 1'b1;
        pend_data_next  = kb_data;
        arb_drop        = rx_valid;
      end else if (rx_valid) begin
        pend_valid_next = 1'b1;
        pend_data_next  = rx_data;
      end
    end else if (kb_valid) begin
      push_req  = 1'b1;
      push_byte = kb_data;
      if (rx_valid) begin
        pend_valid_next = 1'b1;
        pend_data_next  = rx_data;
      end
    end else if (rx_valid) begin
      push_req  = 1'b1;
      push_byte = rx_data;
    end
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      pend_valid <= pend_valid_next;
      pend_data  <= pend_data_next;
    end
  end

  tty_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk_50mhz),
    .rst         (rst),
    .push        (push_req),
    .push_data   (push_byte),
    .push_accept (push_accept),
    .pop         (pop_req),
    .head        (head),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  assign not_empty = ~empty;

  // ---------------------------------------------------------------------------
  // Overflow: set by any dropped byte; set wins over a same-cycle clear.
  // ---------------------------------------------------------------------------
  logic drop;
  assign drop = arb_drop | (push_req & ~push_accept);

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Read FSM: one pop per rd assertion however long rd stays high.
  // ---------------------------------------------------------------------------
  rd_state_t state, state_next;

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rd) state_next = POP;
      POP:     state_next = HOLD;
      HOLD:    if (!rd) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop_req = (state == POP);
  end

  logic [31:0] rd_word;
  always_comb begin
    rd_word                    = '0;
    rd_word[CHAR_W-1:0]        = head;
    rd_word[RD_VALID_BIT]      = 1'b1;
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst)          rd_data <= '0;
    else if (pop_req) rd_data <= empty ? 32'h0 : rd_word;
  end

`ifdef TTY_RXQ_ECHO_EN
  // Mirror each accepted byte for one cycle after it enters the FIFO.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      echo_valid <= 1'b0;
      echo_data  <= '0;
    end else begin
      echo_valid <= push_accept;
      if (push_accept) echo_data <= push_byte;
    end
  end
`endif

endmodule

// File: tb/tb_tty_rx_queue.sv
// tb_tty_rx_queue: directed scenarios plus randomized traffic for
// tty_rx_queue, compared every cycle against a queue-based reference model.
module tb_tty_rx_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk_50mhz = 1'b0;
  logic        rst;
  logic        kb_valid, rx_valid, rd, clr_ovf;
  logic [7:0]  kb_data, rx_data;
  logic [31:0] rd_data;
  logic        not_empty, full, overflow;
  logic [AW:0] count;

  always #5 clk_50mhz = ~clk_50mhz;

  tty_rx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .kb_valid  (kb_valid),
    .kb_data   (kb_data),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rd        (rd),
    .rd_data   (rd_data),
    .not_empty (not_empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the FIFO is a queue, the pending slot a 0/1-entry queue,
  // and reading is tracked as "a pop is owed one cycle after rd is seen while
  // the reader is armed; it re-arms once rd has been seen low".
  // ---------------------------------------------------------------------------
  byte unsigned m_q[$];
  byte unsigned m_slot[$];
  bit           m_ovf;
  logic [31:0]  m_rd_data;
  bit           m_armed;     // ready to accept a new rd assertion
  bit           m_pop_due;   // this cycle performs the pop

  function automatic void model_reset();
    m_q.delete();
    m_slot.delete();
    m_ovf     = 1'b0;
    m_rd_data = 32'h0;
    m_armed   = 1'b1;
    m_pop_due = 1'b0;
  endfunction

  function automatic void model_edge(input bit kv, input byte unsigned kd,
                                     input bit rv, input byte unsigned rxd,
                                     input bit r, input bit c);
    byte unsigned arrivals[$];
    byte unsigned cand;
    bit           have = 0;
    bit           dropped = 0;
    int           size_before = m_q.size();
    bit           popping = m_pop_due && (size_before > 0);

    if (kv) arrivals.push_back(kd);
    if (rv) arrivals.push_back(rxd);
    // Oldest first: the slot content, then new arrivals in kb, rx order.
    if (m_slot.size() > 0) begin
      cand = m_slot.pop_front();
      have = 1;
    end else if (arrivals.size() > 0) begin
      cand = arrivals.pop_front();
      have = 1;
    end
    if (arrivals.size() > 0) m_slot.push_back(arrivals.pop_front());
    if (arrivals.size() > 0) dropped = 1;

    if (m_pop_due) begin
      if (size_before > 0) m_rd_data = 32'h100 | 32'(m_q.pop_front());
      else                 m_rd_data = 32'h0;
    end
    if (have) begin
      if (size_before < DEPTH || popping) m_q.push_back(cand);
      else dropped = 1;
    end

    if (dropped) m_ovf = 1'b1;
    else if (c)  m_ovf = 1'b0;

    // Reader bookkeeping for the next cycle.
    if (m_pop_due) begin
      m_pop_due = 1'b0;
    end else if (m_armed && r) begin
      m_pop_due = 1'b1;
      m_armed   = 1'b0;
    end else if (!m_armed && !r) begin
      m_armed = 1'b1;
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".count"},     32'(count),     32'(m_q.size()));
    check({tag, ".full"},      32'(full),      32'(m_q.size() == DEPTH));
    check({tag, ".not_empty"}, 32'(not_empty), 32'(m_q.size() != 0));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".rd_data"},   rd_data,        m_rd_data);
  endtask

  // One clock cycle: apply inputs, clock, advance model, compare after edge.
  task automatic cyc(input string tag, input bit kv, input byte unsigned kd,
                     input bit rv, input byte unsigned rxd, input bit r, input bit c);
    kb_valid = kv; kb_data = kd;
    rx_valid = rv; rx_data = rxd;
    rd = r; clr_ovf = c;
    @(posedge clk_50mhz);
    model_edge(kv, kd, rv, rxd, r, c);
    #1;
    compare_all(tag);
  endtask

  task automatic read_one(input string tag);
    cyc(tag, 0, 0, 0, 0, 1, 0);
    cyc(tag, 0, 0, 0, 0, 0, 0);
    cyc(tag, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk_50mhz);
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk_50mhz);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    kb_valid = 0; kb_data = 0; rx_valid = 0; rx_data = 0; rd = 0; clr_ovf = 0;
    model_reset();
    #2 rst = 1'b1;
    #10;
    compare_all("reset");
    @(negedge clk_50mhz);
    rst = 1'b0;

    // Single keyboard character, rd held three cycles -> exactly one pop.
    cyc("kb1", 1, 8'h41, 0, 0, 0, 0);
    cyc("kb1.rd", 0, 0, 0, 0, 1, 0);
    cyc("kb1.rd", 0, 0, 0, 0, 1, 0);
    check("kb1.word", rd_data, 32'h0000_0141);
    check("kb1.ne",   32'(not_empty), 32'h0);
    cyc("kb1.rd", 0, 0, 0, 0, 1, 0);
    cyc("kb1.rel", 0, 0, 0, 0, 0, 0);
    cyc("kb1.rel", 0, 0, 0, 0, 0, 0);

    // Both sources in one cycle.
    cyc("both", 1, 8'h61, 1, 8'h62, 0, 0);
    cyc("both", 0, 0, 0, 0, 0, 0);
    check("both.count2", 32'(count), 32'd2);
    read_one("both.r0");
    check("both.first", rd_data, 32'h161);
    read_one("both.r1");
    check("both.second", rd_data, 32'h162);

    // Fill with 17 bytes: 17th dropped, overflow set, then cleared.
    for (int i = 1; i <= 17; i++) cyc("fill", 1, 8'(i), 0, 0, 0, 0);
    check("fill.full", 32'(full), 32'h1);
    check("fill.ovf",  32'(overflow), 32'h1);
    cyc("clr", 0, 0, 0, 0, 0, 1);
    check("clr.ovf", 32'(overflow), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      read_one("drain");
      check("drain.order", rd_data, 32'h100 | 32'(i));
    end

    // Push while full in the POP cycle: accepted, count stays at DEPTH.
    for (int i = 0; i < 16; i++) cyc("refill", 1, 8'(8'h20 + i), 0, 0, 0, 0);
    cyc("pp.rd", 0, 0, 0, 0, 1, 0);
    cyc("pp.pop", 0, 0, 1, 8'hAA, 0, 0);
    check("pp.count", 32'(count), 32'd16);
    check("pp.ovf",   32'(overflow), 32'h0);
    check("pp.word",  rd_data, 32'h120);
    cyc("pp.idle", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) read_one("pp.drain");
    check("pp.last", rd_data, 32'h1AA);

    // Read of an empty FIFO returns an invalid word.
    read_one("empty");
    check("empty.word",  rd_data, 32'h0);
    check("empty.count", 32'(count), 32'd0);

    // Asynchronous reset with 5 entries and a read in flight.
    for (int i = 0; i < 5; i++) cyc("pre_rst", 0, 0, 1, 8'(8'h30 + i), 0, 0);
    cyc("pre_rst.rd", 0, 0, 0, 0, 1, 0);
    rd = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst.count", 32'(count), 32'd0);
    check("arst.rd",    rd_data, 32'h0);
    check("arst.ne",    32'(not_empty), 32'h0);
    #1 rst = 1'b0;
    cyc("post_rst", 1, 8'h55, 0, 0, 0, 0);
    read_one("post_rst");
    check("post_rst.word", rd_data, 32'h155);

    // Randomized traffic.
    apply_reset();
    begin
      bit r = 0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 2) == 0) r = ~r;
        cyc("rand", ($urandom_range(0, 3) == 0), 8'($urandom),
                    ($urandom_range(0, 3) == 0), 8'($urandom),
                    r, ($urandom_range(0, 15) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
